serial_reg_cmd_engine: RTL and testbench

- Byte-stream command engine that sits between the RS232 core's rx/tx byte interfaces and a parametrised internal register file.
- Parses framed read/write commands, validates checksum, command and address, then executes the command.
- Returns a framed response, and drops stalled frames on an inter-byte timeout.
- Successor to the fixed-width serial command skeleton: register count, register width and timeout are parameters, and errors are reported in-band.

---
 rtl/serial_reg_cmd_engine.sv | 265 ++++++++++++++++++++++++++
 tb/tb_serial_reg_cmd_engine.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_reg_cmd_engine.sv
// ============================================================================
// serial_reg_cmd_engine
//
// Byte-stream command engine between an RS232 core's rx/tx byte interfaces
// and a parametrised register file. Parses framed read/write requests,
// validates checksum, command and address, executes the command and returns
// a framed response. Partially received frames are dropped after an
// inter-byte timeout.
//
// Request : AA, CMD, ADDR, DATA[DATA_BYTES] (write only), CHK
// Response: 55, STATUS, ADDR, DATA[DATA_BYTES], CHK
// CHK is the XOR of every byte after the start-of-frame byte.
//
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   rx_data/valid  - incoming byte, accepted when rx_valid && rx_ready
//   rx_ready       - engine can accept a byte (IDLE and receive states)
//   tx_data/valid  - response byte, held stable until tx_ready
//   tx_ready       - transmitter takes the byte when tx_valid && tx_ready
//   reg_out        - flat register file, register i at [(i+1)*W-1 : i*W]
//   reg_wr_strobe  - one-cycle pulse on the bit of the register written
//   busy           - high whenever the engine is not IDLE
//   err_count      - saturating count of error responses plus timeouts
// ============================================================================
module serial_reg_cmd_engine #(
    parameter int REG_COUNT      = 4,
    parameter int DATA_BYTES     = 2,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [7:0]                          rx_data,
    input  logic                                rx_valid,
    output logic                                rx_ready,
    output logic [7:0]                          tx_data,
    output logic                                tx_valid,
    input  logic                                tx_ready,
    output logic [REG_COUNT*DATA_BYTES*8-1:0]   reg_out,
    output logic [REG_COUNT-1:0]                reg_wr_strobe,
    output logic                                busy,
    output logic [7:0]                          err_count
);

    localparam int DATA_W     = 8 * DATA_BYTES;
    localparam int RESP_BYTES = 4 + DATA_BYTES;
    localparam int TOUT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] SOF_REQ    = 8'hAA;
    localparam logic [7:0] SOF_RESP   = 8'h55;
    localparam logic [7:0] CMD_RD     = 8'h01;
    localparam logic [7:0] CMD_WR     = 8'h02;
    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_BAD_CMD = 8'h01;
    localparam logic [7:0] ST_BAD_ADR = 8'h02;
    localparam logic [7:0] ST_BAD_CHK = 8'h03;

    typedef enum logic [2:0] {
        S_IDLE,
        S_R_CMD,
        S_R_ADDR,
        S_R_DATA,
        S_R_CHK,
        S_EXEC,
        S_RESP
    } state_e;

    state_e              state_q, state_d;
    logic [7:0]          cmd_q, cmd_d;
    logic [7:0]          addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [7:0]          chk_q, chk_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [TOUT_W-1:0]   tout_q, tout_d;
    logic [7:0]          status_q, status_d;
    logic [DATA_W-1:0]   resp_data_q, resp_data_d;
    logic [2:0]          tx_idx_q, tx_idx_d;
    logic [7:0]          err_q, err_d;
    logic [DATA_W-1:0]   regs_q [REG_COUNT];
    logic [DATA_W-1:0]   regs_d [REG_COUNT];

    logic                in_frame;
    logic                rx_acc;
    logic                tx_hs;
    logic                tout_hit;
    logic                wr_en;
    logic [7:0]          exec_status;
    logic [DATA_W-1:0]   rd_data;
    logic [7:0]          resp_bytes [RESP_BYTES];

    assign in_frame = (state_q == S_R_CMD) || (state_q == S_R_ADDR) ||
                      (state_q == S_R_DATA) || (state_q == S_R_CHK);
    assign rx_acc   = rx_valid && rx_ready;
    assign tx_hs    = tx_valid && tx_ready;
    // A byte arriving on the final cycle keeps the frame alive.
    assign tout_hit = in_frame && !rx_acc && (tout_q == TOUT_LAST);
    assign wr_en    = (state_q == S_EXEC) && (exec_status == ST_OK) && (cmd_q == CMD_WR);

    // chk_q holds the XOR of every byte after SOF including CHK, so a good
    // frame leaves it at zero. Priority: checksum > command > address.
    always_comb begin
        exec_status = ST_OK;
        if (chk_q != 8'h00) begin
            exec_status = ST_BAD_CHK;
        end else if ((cmd_q != CMD_RD) && (cmd_q != CMD_WR)) begin
            exec_status = ST_BAD_CMD;
        end else if (int'(addr_q) >= REG_COUNT) begin
            exec_status = ST_BAD_ADR;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (addr_q == 8'(i)) rd_data = regs_q[i];
        end
    end

    // ------------------------------------------------------------------
    // FSM process 1: state and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge value, so process order never changes behaviour.
        if (rst) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            chk_q       <= '0;
            cnt_q       <= '0;
            tout_q      <= '0;
            status_q    <= '0;
            resp_data_q <= '0;
            tx_idx_q    <= '0;
            err_q       <= '0;
            // NOTE: the register file is architecturally visible on reg_out
            // and must read zero after reset, so it is reset explicitly
            // rather than left to power-up contents.
            for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            chk_q       <= chk_d;
            cnt_q       <= cnt_d;
            tout_q      <= tout_d;
            status_q    <= status_d;
            resp_data_q <= resp_data_d;
            tx_idx_q    <= tx_idx_d;
            err_q       <= err_d;
            regs_q      <= regs_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: assigning a default first covers every path through the
        // case, so no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (rx_acc && (rx_data == SOF_REQ)) state_d = S_R_CMD;
            S_R_CMD:  if (rx_acc) state_d = S_R_ADDR;
                      else if (tout_hit) state_d = S_IDLE;
            S_R_ADDR: if (rx_acc) state_d = (cmd_q == CMD_WR) ? S_R_DATA : S_R_CHK;
                      else if (tout_hit) state_d = S_IDLE;
            S_R_DATA: if (rx_acc && (cnt_q == 2'(DATA_BYTES - 1))) state_d = S_R_CHK;
                      else if (tout_hit) state_d = S_IDLE;
            S_R_CHK:  if (rx_acc) state_d = S_EXEC;
                      else if (tout_hit) state_d = S_IDLE;
            S_EXEC:   state_d = S_RESP;
            S_RESP:   if (tx_hs && (tx_idx_q == 3'(RESP_BYTES - 1))) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath next-state: frame capture, execution and response indexing.
    always_comb begin
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        data_d      = data_q;
        chk_d       = chk_q;
        cnt_d       = cnt_q;
        tout_d      = '0;
        status_d    = status_q;
        resp_data_d = resp_data_q;
        tx_idx_d    = tx_idx_q;
        err_d       = err_q;
        regs_d      = regs_q;

        if (in_frame) begin
            if (rx_acc) chk_d = chk_q ^ rx_data;
            else if (!tout_hit) tout_d = tout_q + TOUT_W'(1);
        end

        case (state_q)
            S_IDLE:   chk_d = '0;
            S_R_CMD:  if (rx_acc) cmd_d = rx_data;
            S_R_ADDR: if (rx_acc) begin
                          addr_d = rx_data;
                          cnt_d  = '0;
                          data_d = '0;
                      end
            S_R_DATA: if (rx_acc) begin
                          data_d = (data_q << 8) | DATA_W'(rx_data);
                          cnt_d  = cnt_q + 2'd1;
                      end
            S_EXEC: begin
                status_d = exec_status;
                tx_idx_d = '0;
                if (exec_status != ST_OK) resp_data_d = '0;
                else if (cmd_q == CMD_WR) resp_data_d = data_q;
                else resp_data_d = rd_data;
                if ((exec_status != ST_OK) && (err_q != 8'hFF)) err_d = err_q + 8'd1;
            end
            S_RESP:   if (tx_hs) tx_idx_d = tx_idx_q + 3'd1;
            default: ;
        endcase

        if (tout_hit && (err_q != 8'hFF)) err_d = err_q + 8'd1;

        for (int i = 0; i < REG_COUNT; i++) begin
            if (wr_en && (addr_q == 8'(i))) regs_d[i] = data_q;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 3: outputs
    // ------------------------------------------------------------------
    always_comb begin
        rx_ready      = (state_q == S_IDLE) || in_frame;
        tx_valid      = (state_q == S_RESP);
        busy          = (state_q != S_IDLE);
        err_count     = err_q;
        reg_wr_strobe = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            reg_wr_strobe[i] = wr_en && (addr_q == 8'(i));
        end

        resp_bytes[0] = SOF_RESP;
        resp_bytes[1] = status_q;
        resp_bytes[2] = addr_q;
        resp_bytes[RESP_BYTES-1] = status_q ^ addr_q;
        for (int k = 0; k < DATA_BYTES; k++) begin
            resp_bytes[3+k] = resp_data_q[(DATA_BYTES-1-k)*8 +: 8];
            resp_bytes[RESP_BYTES-1] = resp_bytes[RESP_BYTES-1] ^ resp_bytes[3+k];
        end

        tx_data = '0;
        if (state_q == S_RESP) begin
            for (int i = 0; i < RESP_BYTES; i++) begin
                if (tx_idx_q == 3'(i)) tx_data = resp_bytes[i];
            end
        end

        reg_out = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            reg_out[i*DATA_W +: DATA_W] = regs_q[i];
        end
    end

endmodule

// File: tb/tb_serial_reg_cmd_engine.sv
// ============================================================================
// tb_serial_reg_cmd_engine
//
// Directed bench for serial_reg_cmd_engine with REG_COUNT=4, DATA_BYTES=2,
// TIMEOUT_CYCLES=100. Inputs change and outputs are sampled on the falling
// clock edge; the design acts on the rising edge.
// ============================================================================
module tb_serial_reg_cmd_engine;

    localparam int REG_COUNT      = 4;
    localparam int DATA_BYTES     = 2;
    localparam int TIMEOUT_CYCLES = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [63:0] reg_out;
    logic [3:0]  reg_wr_strobe;
    logic        busy;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;
    int exp_err = 0;

    // Running observations of strobe pulses and offered tx bytes.
    int         strobe_cnt  = 0;
    logic [3:0] strobe_last = '0;
    int         txv_cnt     = 0;

    serial_reg_cmd_engine #(
        .REG_COUNT      (REG_COUNT),
        .DATA_BYTES     (DATA_BYTES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .reg_out       (reg_out),
        .reg_wr_strobe (reg_wr_strobe),
        .busy          (busy),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reg_wr_strobe != '0) begin
            strobe_cnt  <= strobe_cnt + 1;
            strobe_last <= reg_wr_strobe;
        end
        if (tx_valid === 1'b1) txv_cnt <= txv_cnt + 1;
    end

    // Offer one byte and hold it until the engine accepts it.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL send_byte: rx_ready=%b after 200 cycles, required 1", rx_ready);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_frame(input logic [63:0] v, input int nbytes);
        for (int i = 0; i < nbytes; i++) send_byte(v[(nbytes-1-i)*8 +: 8]);
    endtask

    // Collect a 6-byte response with tx_ready held high.
    task automatic recv_resp(output logic [47:0] r);
        int got;
        int n;
        got = 0;
        n = 0;
        r = '0;
        tx_ready = 1'b1;
        while (got < 6 && n < 100) begin
            if (tx_valid === 1'b1) begin
                r = {r[39:0], tx_data};
                got++;
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (got < 6) begin
            errors++;
            $display("FAIL recv_resp: got %0d bytes, required 6", got);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, tx_valid, rx_ready} !== 3'b001) begin
            errors++;
            $display("FAIL reset_flags: busy,tx_valid,rx_ready=%b required 001", {busy, tx_valid, rx_ready});
        end
        checks++;
        if (tx_data !== 8'h00 || reg_wr_strobe !== 4'h0) begin
            errors++;
            $display("FAIL reset_tx: tx_data=%h strobe=%b required 00 0000", tx_data, reg_wr_strobe);
        end
        checks++;
        if (reg_out !== 64'h0 || err_count !== 8'h00) begin
            errors++;
            $display("FAIL reset_regs: reg_out=%h err=%0d required 0 0", reg_out, err_count);
        end
    endtask

    task automatic test_write();
        logic [47:0] r;
        int s0;
        s0 = strobe_cnt;
        send_frame(64'hAA_02_01_12_34_25, 6);
        recv_resp(r);
        checks++;
        if (r !== 48'h55_00_01_12_34_27) begin
            errors++;
            $display("FAIL write_resp: got %h required 550001123427", r);
        end
        checks++;
        if (strobe_cnt - s0 != 1 || strobe_last !== 4'b0010) begin
            errors++;
            $display("FAIL write_strobe: pulses=%0d last=%b required 1 0010", strobe_cnt - s0, strobe_last);
        end
        checks++;
        if (reg_out !== 64'h0000_0000_1234_0000) begin
            errors++;
            $display("FAIL write_reg: reg_out=%h required 0000000012340000", reg_out);
        end
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || err_count !== 8'(exp_err)) begin
            errors++;
            $display("FAIL write_end: tx_valid=%b busy=%b err=%0d required 0 0 %0d", tx_valid, busy, err_count, exp_err);
        end
    endtask

    task automatic test_read();
        logic [47:0] r;
        int s0;
        s0 = strobe_cnt;
        send_frame(64'hAA_01_01_00, 4);
        recv_resp(r);
        checks++;
        if (r !== 48'h55_00_01_12_34_27) begin
            errors++;
            $display("FAIL read_resp: got %h required 550001123427", r);
        end
        checks++;
        if (strobe_cnt != s0) begin
            errors++;
            $display("FAIL read_strobe: pulses=%0d required 0", strobe_cnt - s0);
        end
    endtask

    task automatic test_bad_addr();
        logic [47:0] r;
        send_frame(64'hAA_01_07_06, 4);
        recv_resp(r);
        exp_err++;
        checks++;
        if (r !== 48'h55_02_07_00_00_05) begin
            errors++;
            $display("FAIL bad_addr_resp: got %h required 550207000005", r);
        end
        checks++;
        if (err_count !== 8'(exp_err)) begin
            errors++;
            $display("FAIL bad_addr_err: err=%0d required %0d", err_count, exp_err);
        end
    endtask

    task automatic test_bad_checksum();
        logic [47:0] r;
        // Leading 00 3C garbage must be ignored in IDLE.
        send_frame(64'h00_3C_AA_05_01_FF, 6);
        recv_resp(r);
        exp_err++;
        checks++;
        if (r !== 48'h55_03_01_00_00_02) begin
            errors++;
            $display("FAIL bad_chk_resp: got %h required 550301000002", r);
        end
        checks++;
        if (err_count !== 8'(exp_err) || reg_out !== 64'h0000_0000_1234_0000) begin
            errors++;
            $display("FAIL bad_chk_state: err=%0d reg_out=%h required %0d 0000000012340000", err_count, reg_out, exp_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [47:0] r;
        int s0;
        s0 = strobe_cnt;
        // Data byte AA inside the frame is plain data, not a resync.
        send_frame(64'hAA_02_02_AA_55_FF, 6);
        recv_resp(r);
        checks++;
        if (r !== 48'h55_00_02_AA_55_FD) begin
            errors++;
            $display("FAIL b2b_aa_resp: got %h required 550002AA55FD", r);
        end
        // Highest valid address.
        send_frame(64'hAA_02_03_00_01_00, 6);
        recv_resp(r);
        checks++;
        if (r !== 48'h55_00_03_00_01_02) begin
            errors++;
            $display("FAIL b2b_top_resp: got %h required 550003000102", r);
        end
        checks++;
        if (strobe_cnt - s0 != 2 || strobe_last !== 4'b1000) begin
            errors++;
            $display("FAIL b2b_strobe: pulses=%0d last=%b required 2 1000", strobe_cnt - s0, strobe_last);
        end
        // First address past the end.
        send_frame(64'hAA_01_04_05, 4);
        recv_resp(r);
        exp_err++;
        checks++;
        if (r !== 48'h55_02_04_00_00_06) begin
            errors++;
            $display("FAIL b2b_oob_resp: got %h required 550204000006", r);
        end
        checks++;
        if (reg_out !== 64'h0001_AA55_1234_0000 || err_count !== 8'(exp_err)) begin
            errors++;
            $display("FAIL b2b_state: reg_out=%h err=%0d required 0001AA5512340000 %0d", reg_out, err_count, exp_err);
        end
    endtask

    task automatic test_timeout();
        logic [47:0] r;
        int t0;
        int n;
        t0 = txv_cnt;
        send_frame(64'hAA_01, 2);
        repeat (90) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: busy=%b after 90 idle cycles, required 1", busy);
        end
        n = 0;
        while (busy !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL timeout_late: busy=%b after 110 idle cycles, required 0", busy);
        end
        exp_err++;
        @(negedge clk);
        checks++;
        if (txv_cnt != t0 || err_count !== 8'(exp_err)) begin
            errors++;
            $display("FAIL timeout_state: tx bytes=%0d err=%0d required 0 %0d", txv_cnt - t0, err_count, exp_err);
        end
        send_frame(64'hAA_01_01_00, 4);
        recv_resp(r);
        checks++;
        if (r !== 48'h55_00_01_12_34_27) begin
            errors++;
            $display("FAIL timeout_recover: got %h required 550001123427", r);
        end
    endtask

    task automatic test_backpressure_reset();
        logic [7:0] first;
        int n;
        int unstable;
        int t0;
        tx_ready = 1'b0;
        send_frame(64'hAA_01_01_00, 4);
        n = 0;
        while (tx_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        first = tx_data;
        checks++;
        if (n >= 20 || first !== 8'h55) begin
            errors++;
            $display("FAIL bp_first: tx_valid=%b tx_data=%h required 1 55", tx_valid, first);
        end
        unstable = 0;
        for (int i = 0; i < 50; i++) begin
            if (tx_valid !== 1'b1 || tx_data !== first || rx_ready !== 1'b0) unstable++;
            @(negedge clk);
        end
        checks++;
        if (unstable != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d unstable cycles, required 0", unstable);
        end
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL bp_advance: tx_valid=%b tx_data=%h required 1 00", tx_valid, tx_data);
        end
        rst = 1'b1;
        @(negedge clk);
        exp_err = 0;
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_abort: tx_valid=%b busy=%b rx_ready=%b required 0 0 1", tx_valid, busy, rx_ready);
        end
        checks++;
        if (reg_out !== 64'h0 || err_count !== 8'h00) begin
            errors++;
            $display("FAIL rst_clear: reg_out=%h err=%0d required 0 0", reg_out, err_count);
        end
        rst = 1'b0;
        tx_ready = 1'b1;
        t0 = txv_cnt;
        repeat (10) @(negedge clk);
        checks++;
        if (txv_cnt != t0) begin
            errors++;
            $display("FAIL rst_no_tx: %0d bytes offered after reset, required 0", txv_cnt - t0);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bad_addr();
        test_bad_checksum();
        test_back_to_back();
        test_timeout();
        test_backpressure_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
